// File: rtl/display7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: sequences digit codes and active-low
// anodes with a blanking gap per slot, and double-buffers new contents to frame edges.
module display7_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int DIV          = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] iDigits,
  input  logic [NUM_DIGITS-1:0]   iEnMask,
  input  logic                    iValid,
  output logic                    oReady,
  output logic [3:0]              oDecIn,
  output logic [NUM_DIGITS-1:0]   oAn,
  output logic                    oFrame,
  output logic                    o_dbg_state
);

  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  logic [IW-1:0]           w_idx_next;
  logic [4*NUM_DIGITS-1:0] r_buf;
  logic [NUM_DIGITS-1:0]   r_mask;
  logic [4*NUM_DIGITS-1:0] r_sh_digits;
  logic [NUM_DIGITS-1:0]   r_sh_mask;
  logic                    r_pending;
  logic [3:0]              r_dec;
  logic [3:0]              w_dec_next;
  logic [NUM_DIGITS-1:0]   r_an;
  logic [NUM_DIGITS-1:0]   w_an_next;
  logic                    w_slot_end;
  logic                    w_frame_end;
  logic                    w_xfer;

  // Handshake: a word transfers on any rising edge where iValid and oReady are both 1;
  // oReady is low exactly while a captured word waits for the next frame boundary.
  assign w_slot_end  = (r_cnt == CNT_LAST);
  assign w_frame_end = w_slot_end && (r_idx == IDX_LAST);
  assign w_xfer      = iValid && !r_pending;
  assign w_idx_next  = w_slot_end ? ((r_idx == IDX_LAST) ? '0 : r_idx + 1'b1) : r_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      r_cnt <= w_slot_end ? '0 : r_cnt + 1'b1;
      r_idx <= w_idx_next;
    end
  end

  // Buffer copy uses the pre-edge shadow; a word captured on the same edge waits a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf       <= '0;
      r_mask      <= '0;
      r_sh_digits <= '0;
      r_sh_mask   <= '0;
      r_pending   <= 1'b0;
    end else begin
      if (w_frame_end && r_pending) begin
        r_buf  <= r_sh_digits;
        r_mask <= r_sh_mask;
      end
      if (w_xfer) begin
        r_sh_digits <= iDigits;
        r_sh_mask   <= iEnMask;
        r_pending   <= 1'b1;
      end else if (w_frame_end) begin
        r_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_BLANK;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_BLANK: if (r_cnt == BLANK_LAST) w_state_next = ST_SHOW;
      ST_SHOW:  if (w_slot_end)          w_state_next = ST_BLANK;
      default:  w_state_next = ST_BLANK;
    endcase
  end

  // Next-cycle decoder code and anode pattern, registered below.
  always_comb begin
    w_dec_next = r_dec;
    if (w_slot_end) begin
      if (w_frame_end && r_pending) w_dec_next = r_sh_digits[3:0];
      else                          w_dec_next = r_buf[w_idx_next*4 +: 4];
    end
    w_an_next = '1;
    if (w_state_next == ST_SHOW && r_mask[r_idx]) w_an_next[r_idx] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dec <= '0;
      r_an  <= '1;
    end else begin
      r_dec <= w_dec_next;
      r_an  <= w_an_next;
    end
  end

  assign oReady      = !r_pending;
  assign oDecIn      = r_dec;
  assign oAn         = r_an;
  assign oFrame      = w_frame_end;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_display7_scan_ctrl.sv
// Bench for display7_scan_ctrl: directed scenarios plus random traffic, checked every
// cycle against a time-indexed model of the scan and double-buffer rules.
module tb_display7_scan_ctrl;

  localparam int N     = 4;
  localparam int DIV   = 20;
  localparam int BLANK = 4;
  localparam int FRAME = N * DIV;

  logic          clk;
  logic          rst_n;
  logic [4*N-1:0] i_digits;
  logic [N-1:0]   i_en_mask;
  logic          i_valid;
  logic          o_ready;
  logic [3:0]    o_dec_in;
  logic [N-1:0]  o_an;
  logic          o_frame;
  logic          o_dbg_state;

  display7_scan_ctrl #(.NUM_DIGITS(N), .DIV(DIV), .BLANK_CYCLES(BLANK)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .iDigits     (i_digits),
    .iEnMask     (i_en_mask),
    .iValid      (i_valid),
    .oReady      (o_ready),
    .oDecIn      (o_dec_in),
    .oAn         (o_an),
    .oFrame      (o_frame),
    .o_dbg_state (o_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: t = rising edges since reset release
  int             t;
  logic [4*N-1:0] m_disp_d;
  logic [N-1:0]   m_disp_m;
  logic [4*N-1:0] m_sh_d;
  logic [N-1:0]   m_sh_m;
  logic           m_pend;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d: got %0h expected %0h", tag, t, obs, exp);
    end
  endtask

  function automatic int slot_of(input int tt);
    return (tt / DIV) % N;
  endfunction

  task automatic model_reset();
    t = 0;
    m_disp_d = '0;
    m_disp_m = '0;
    m_sh_d = '0;
    m_sh_m = '0;
    m_pend = 1'b0;
  endtask

  task automatic check_outputs();
    int s, c;
    logic [N-1:0] exp_an;
    s = slot_of(t);
    c = t % DIV;
    exp_an = '1;
    if (c >= BLANK && m_disp_m[s]) exp_an[s] = 1'b0;
    check_eq("an", 32'(o_an), 32'(exp_an));
    check_eq("dec", 32'(o_dec_in), 32'(m_disp_d[s*4 +: 4]));
    check_eq("frame", 32'(o_frame), 32'((s == N-1) && (c == DIV-1)));
    check_eq("ready", 32'(o_ready), 32'(!m_pend));
  endtask

  // driver: called just after a falling edge, returns just after the next one
  task automatic step(input logic v, input logic [4*N-1:0] d, input logic [N-1:0] m);
    logic boundary, pre_pend;
    check_outputs();
    i_valid = v;
    i_digits = d;
    i_en_mask = m;
    @(posedge clk);
    pre_pend = m_pend;
    boundary = (slot_of(t) == N-1) && (t % DIV == DIV-1);
    if (boundary && pre_pend) begin
      m_disp_d = m_sh_d;
      m_disp_m = m_sh_m;
      m_pend = 1'b0;
    end
    if (v && !pre_pend) begin
      m_sh_d = d;
      m_sh_m = m;
      m_pend = 1'b1;
    end
    t++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom, $urandom);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_an", 32'(o_an), 32'({N{1'b1}}));
    check_eq("rst_ready", 32'(o_ready), 32'd1);
    check_eq("rst_dec", 32'(o_dec_in), 32'd0);
    check_eq("rst_frame", 32'(o_frame), 32'd0);
    check_eq("rst_state", 32'(o_dbg_state), 32'd0);
  endtask

  initial begin
    int guard;
    logic found;
    rst_n = 1'b0;
    i_valid = 1'b0;
    i_digits = '0;
    i_en_mask = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;

    // dark display for two frames after reset
    idle(2 * FRAME);

    // full-mask word
    step(1'b1, 16'h3210, 4'b1111);
    idle(2 * FRAME + 10);

    // partial mask
    found = 1'b0;
    for (guard = 0; guard < 2 * FRAME && !found; guard++) begin
      if (!m_pend) found = 1'b1;
      else idle(1);
    end
    check_eq("wait_ready1", 32'(found), 32'd1);
    step(1'b1, 16'hA5C9, 4'b0101);
    idle(2 * FRAME);

    // transfer on the frame-boundary edge
    found = 1'b0;
    for (guard = 0; guard < 3 * FRAME && !found; guard++) begin
      if (!m_pend && (t % FRAME == FRAME - 1)) found = 1'b1;
      else idle(1);
    end
    check_eq("wait_boundary", 32'(found), 32'd1);
    step(1'b1, 16'h7777, 4'b1111);
    idle(2 * FRAME + 5);

    // iValid held high with changing data
    for (int i = 0; i < 3 * FRAME; i++) step(1'b1, $urandom, $urandom);

    // random traffic
    for (int i = 0; i < 12 * FRAME; i++) step(($urandom_range(0, 7) == 0), $urandom, $urandom);

    // reset during SHOW of digit 2 with a word pending
    found = 1'b0;
    for (guard = 0; guard < 3 * FRAME && !found; guard++) begin
      if (!m_pend && (t % FRAME == 0)) found = 1'b1;
      else idle(1);
    end
    check_eq("wait_frame_start", 32'(found), 32'd1);
    step(1'b1, 16'hBEEF, 4'b1111);
    found = 1'b0;
    for (guard = 0; guard < FRAME && !found; guard++) begin
      if (slot_of(t) == 2 && (t % DIV) == BLANK + 3) found = 1'b1;
      else idle(1);
    end
    check_eq("wait_show2", 32'(found), 32'd1);
    check_eq("pending_before_rst", 32'(o_ready), 32'd0);
    i_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(3 * FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
